// File: rtl/dmem_responder.sv
// Memory-side end of a valid/ready load/store port: one request in flight, fixed wait, byte-strobed writes.
// Optional macro MISALIGN_ERR_EN turns misaligned loads and strobe/offset mismatches on stores into errors.
module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;

  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              out_of_range;
  logic              misalign_err;
  logic              req_err;
  logic              capture;
  logic              rsp_done;
  logic              mem_wr;

  assign word_idx     = addr_q[ADDR_W-1:2];
  assign mem_idx      = addr_q[IDX_W+1:2];
  assign out_of_range = (word_idx >= (ADDR_W-2)'(DEPTH_WORDS));

`ifdef MISALIGN_ERR_EN
  logic [3:0] low_mask;
  logic [2:0] strb_cnt;
  always_comb begin
    low_mask     = (4'b0001 << addr_q[1:0]) - 4'b0001;
    strb_cnt     = 3'(wstrb_q[0]) + 3'(wstrb_q[1]) + 3'(wstrb_q[2]) + 3'(wstrb_q[3]);
    misalign_err = 1'b0;
    if (addr_q[1:0] != 2'b00) begin
      if (!we_q) begin
        misalign_err = 1'b1;
      end else if (|(wstrb_q & low_mask) || (addr_q[0] && strb_cnt == 3'd2)) begin
        misalign_err = 1'b1;
      end
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

  assign req_err = out_of_range || misalign_err;

  // The array is touched on the first RESP cycle, before rsp_valid rises.
  assign capture  = (state_q == ST_RESP) && !rsp_valid_q;
  assign rsp_done = (state_q == ST_RESP) && rsp_valid_q && rsp_ready;
  assign mem_wr   = capture && we_q && !req_err;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: begin
        if (capture) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = req_err;
        end else if (rsp_done) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // One byte-wide array per lane so each strobe maps onto its own RAM write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
    logic [7:0] mem_lane [DEPTH_WORDS];
    logic [7:0] rdata_lane_q;

    always_ff @(posedge clk) begin
      if (mem_wr && wstrb_q[gi]) mem_lane[mem_idx] <= wdata_q[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_lane_q <= 8'h00;
      end else if (capture) begin
        rdata_lane_q <= (we_q || req_err) ? 8'h00 : mem_lane[mem_idx];
      end else if (rsp_done) begin
        rdata_lane_q <= 8'h00;
      end
    end

    assign rsp_rdata[8*gi +: 8] = rdata_lane_q;
  end

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
